// File: rtl/mmio_pkg.sv
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared constants and types for the mmio_bridge slice: bus
//                command codes, FSM state encoding, address-region enum and
//                default MMIO base addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

  // CPU memory-port command codes (2'b11 is treated as no command)
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  // Bridge FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Address regions, listed in decode priority order
  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_OUT      = 2'd1,
    REG_IN       = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_t;

  // Default MMIO base addresses for the 9-bit address map
  localparam logic [8:0] DEF_OUT_BASE = 9'h100;
  localparam logic [8:0] DEF_IN_BASE  = 9'h140;

endpackage

`default_nettype wire

// File: rtl/mmio_sync2.sv
// ============================================================================
//  Module      : mmio_sync2
//  Description : DATA_W-wide two-flop synchroniser for asynchronous input
//                ports, cleared by the asynchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_sync2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_meta;
  logic [DATA_W-1:0] r_sync;

  // Two back-to-back flops give the first stage a full cycle to settle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// ============================================================================
//  Module      : mmio_bridge
//  Description : Memory-mapped bridge between the CPU memory port and a
//                synchronous RAM, N_OUT write-only output registers and N_IN
//                synchronised input ports, with a one-cycle mem_ready pulse.
//                Optional macro MMIO_ERR_EN: sticky bus_err on unmapped
//                accesses and all-ones data for unmapped reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 9,
  parameter int                RAM_AW   = 8,
  parameter int                RD_LAT   = 1,
  parameter int                N_OUT    = 2,
  parameter int                N_IN     = 1,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(DEF_OUT_BASE),
  parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(DEF_IN_BASE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       write_data,
  output logic [DATA_W-1:0]       read_data,
  output logic                    mem_ready,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic                    bus_err
);

`ifdef MMIO_ERR_EN
  localparam logic [DATA_W-1:0] c_unmapped_rd = '1;
`else
  localparam logic [DATA_W-1:0] c_unmapped_rd = '0;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  region_t             w_region;
  region_t             r_region;
  logic                r_is_read;
  logic                w_accept;
  logic                w_is_write;
  logic [ADDR_W-1:0]   w_out_off;
  logic [ADDR_W-1:0]   w_in_off;
  logic [DATA_W-1:0]   w_mmio_val;
  logic [DATA_W-1:0]   r_mmio_q;
  logic [DATA_W-1:0]   r_mem [2**RAM_AW];
  logic [DATA_W-1:0]   r_ram_q;
  logic [DATA_W-1:0]   w_ram_rd;
  logic [RAM_AW-1:0]   w_ram_idx;
  logic [DATA_W-1:0]   r_out [N_OUT];
  logic [DATA_W-1:0]   w_in_sync [N_IN];

  assign w_is_write = (mem_cmd == MWRITE);
  assign w_accept   = (r_state == S_IDLE) && ((mem_cmd == MWRITE) || (mem_cmd == MREAD));
  assign w_out_off  = mem_addr - OUT_BASE;
  assign w_in_off   = mem_addr - IN_BASE;
  assign w_ram_idx  = mem_addr[RAM_AW-1:0];

  // Address decode: RAM wins on MSB=0, then OUT range, then IN range
  always_comb begin
    w_region = REG_UNMAPPED;
    if (!mem_addr[ADDR_W-1])
      w_region = REG_RAM;
    else if (w_out_off < ADDR_W'(N_OUT))
      w_region = REG_OUT;
    else if (w_in_off < ADDR_W'(N_IN))
      w_region = REG_IN;
  end

  // Read value for every non-RAM region, captured at accept time
  always_comb begin
    w_mmio_val = '0;
    case (w_region)
      REG_OUT: begin
        for (int i = 0; i < N_OUT; i++)
          if (w_out_off == ADDR_W'(i)) w_mmio_val = r_out[i];
      end
      REG_IN: begin
        for (int i = 0; i < N_IN; i++)
          if (w_in_off == ADDR_W'(i)) w_mmio_val = w_in_sync[i];
      end
      REG_UNMAPPED: w_mmio_val = c_unmapped_rd;
      default:      w_mmio_val = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: only RAM reads with two-cycle latency pass through WAIT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((w_region == REG_RAM) && !w_is_write && (RD_LAT == 2))
            w_state_nxt = S_WAIT;
          else
            w_state_nxt = S_RESP;
        end
      end
      S_WAIT:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the access attributes and MMIO read value at accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_region  <= REG_RAM;
      r_is_read <= 1'b0;
      r_mmio_q  <= '0;
    end else if (w_accept) begin
      r_region  <= w_region;
      r_is_read <= !w_is_write;
      r_mmio_q  <= w_mmio_val;
    end
  end

  // Synchronous RAM: write or registered read at accept, contents never cleared
  always_ff @(posedge clk) begin
    if (w_accept && (w_region == REG_RAM)) begin
      if (w_is_write) r_mem[w_ram_idx] <= write_data;
      else            r_ram_q          <= r_mem[w_ram_idx];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_ram_q2;

      // Extra RAM output register loaded during the WAIT cycle
      always_ff @(posedge clk) begin
        if (r_state == S_WAIT) r_ram_q2 <= r_ram_q;
      end

      assign w_ram_rd = r_ram_q2;
    end else begin : g_lat1
      assign w_ram_rd = r_ram_q;
    end
  endgenerate

  // Output registers written at accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
    end else if (w_accept && w_is_write && (w_region == REG_OUT)) begin
      for (int i = 0; i < N_OUT; i++)
        if (w_out_off == ADDR_W'(i)) r_out[i] <= write_data;
    end
  end

  generate
    for (genvar g = 0; g < N_OUT; g++) begin : g_out
      assign out_port[g*DATA_W +: DATA_W] = r_out[g];
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
      mmio_sync2 #(
        .DATA_W (DATA_W)
      ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port[g*DATA_W +: DATA_W]),
        .q     (w_in_sync[g])
      );
    end
  endgenerate

`ifdef MMIO_ERR_EN
  logic r_bus_err;

  // Sticky flag for any unmapped read or write
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_bus_err <= 1'b0;
    else if (w_accept && (w_region == REG_UNMAPPED)) r_bus_err <= 1'b1;
  end

  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

  // Response: data is driven only during the ready pulse of a read
  always_comb begin
    read_data = '0;
    if ((r_state == S_RESP) && r_is_read)
      read_data = (r_region == REG_RAM) ? w_ram_rd : r_mmio_q;
  end

  assign mem_ready = (r_state == S_RESP);

endmodule

`default_nettype wire
